// File: rtl/monostable_555.sv
// Digital 555 timer in monostable mode: a falling trigger edge starts a pulse lasting
// o_Position scan lines. Optional retriggering is enabled by defining MONOSTABLE_RETRIGGER_EN.
module monostable_555 #(
  parameter int p_COUNT_WIDTH = 10,
  parameter int p_MIN_LINES   = 2,
  parameter int p_MAX_LINES   = 420,
  parameter int p_INIT_LINES  = 200,
  parameter int p_STEP        = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_Trigger,
  input  logic                     i_HReset,
  input  logic                     i_Up,
  input  logic                     i_Down,
  output logic                     o_Output,
  output logic                     o_Done,
  output logic [p_COUNT_WIDTH-1:0] o_Position
);

  localparam logic [p_COUNT_WIDTH-1:0] MIN_W  = p_COUNT_WIDTH'(p_MIN_LINES);
  localparam logic [p_COUNT_WIDTH-1:0] MAX_W  = p_COUNT_WIDTH'(p_MAX_LINES);
  localparam logic [p_COUNT_WIDTH-1:0] INIT_W = p_COUNT_WIDTH'(p_INIT_LINES);
  localparam logic [p_COUNT_WIDTH-1:0] STEP_W = p_COUNT_WIDTH'(p_STEP);
  localparam logic [p_COUNT_WIDTH-1:0] ONE_W  = p_COUNT_WIDTH'(1);

  typedef enum logic {
    S_IDLE,
    S_TIMING
  } state_t;

  state_t                   state_q, state_d;
  logic [p_COUNT_WIDTH-1:0] count_q, count_d;
  logic [p_COUNT_WIDTH-1:0] pos_q, pos_d;
  logic [p_COUNT_WIDTH-1:0] next_pos;
  logic [p_COUNT_WIDTH:0]   up_floor;
  logic [p_COUNT_WIDTH:0]   down_sum;
  logic                     output_q, output_d;
  logic                     done_q, done_d;
  logic                     trig_q;
  logic                     start;

  assign start = trig_q & ~i_Trigger;

  // Potentiometer model: one extra bit keeps the saturating step free of wrap-around.
  always_comb begin
    up_floor = {1'b0, MIN_W} + {1'b0, STEP_W};
    down_sum = {1'b0, pos_q} + {1'b0, STEP_W};
    next_pos = pos_q;
    if (i_Up && !i_Down) begin
      next_pos = ({1'b0, pos_q} >= up_floor) ? (pos_q - STEP_W) : MIN_W;
    end else if (i_Down && !i_Up) begin
      next_pos = (down_sum > {1'b0, MAX_W}) ? MAX_W : down_sum[p_COUNT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pos_d    = pos_q;
    output_d = output_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pos_d    = next_pos;
          count_d  = next_pos;
          state_d  = S_TIMING;
          output_d = 1'b1;
        end
      end
      S_TIMING: begin
`ifdef MONOSTABLE_RETRIGGER_EN
        if (start) begin
          pos_d    = next_pos;
          count_d  = next_pos;
          output_d = 1'b1;
        end else if (i_HReset) begin
          if (count_q > ONE_W) begin
            count_d = count_q - ONE_W;
          end else begin
            state_d  = S_IDLE;
            output_d = 1'b0;
            done_d   = 1'b1;
            count_d  = '0;
          end
        end
`else
        if (i_HReset) begin
          if (count_q > ONE_W) begin
            count_d = count_q - ONE_W;
          end else begin
            state_d  = S_IDLE;
            output_d = 1'b0;
            done_d   = 1'b1;
            count_d  = '0;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      pos_q    <= INIT_W;
      output_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pos_q    <= pos_d;
      output_q <= output_d;
      done_q   <= done_d;
    end
  end

  // Tracks the trigger even under reset, so a trigger held low through reset cannot fire on release.
  always_ff @(posedge i_Clk) begin
    trig_q <= i_Trigger;
  end

  assign o_Output   = output_q;
  assign o_Done     = done_q;
  assign o_Position = pos_q;

endmodule

// File: tb/tb_monostable_555.sv
// Directed bench for monostable_555: pulse length, position stepping/saturation,
// retrigger behaviour (both builds) and mid-pulse reset.
module tb_monostable_555;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Trigger = 1'b0;
  logic       i_HReset = 1'b0;
  logic       i_Up = 1'b0;
  logic       i_Down = 1'b0;
  logic       o_Output;
  logic       o_Done;
  logic [9:0] o_Position;

  int n_tests = 0;
  int n_fail  = 0;

  monostable_555 dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Trigger  (i_Trigger),
    .i_HReset   (i_HReset),
    .i_Up       (i_Up),
    .i_Down     (i_Down),
    .o_Output   (o_Output),
    .o_Done     (o_Done),
    .o_Position (o_Position)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fire(input logic hr);
    i_HReset  = hr;
    i_Trigger = 1'b0;
    tick();
    i_Trigger = 1'b1;
    i_HReset  = 1'b0;
  endtask

  // Runs the pulse already started: counts HResets seen while o_Output is high and o_Done cycles.
  task automatic run_pulse(input int period, input int retrig_at, input int rst_at,
                           output int lines, output int dones, output bit ended);
    int cyc;
    bit retrigged;
    logic out_b, hr_b;
    cyc = 0; retrigged = 0;
    lines = 0; dones = 0; ended = 0;
    while (cyc < 20000) begin
      if (rst_at > 0 && lines == rst_at) begin
        i_HReset = 1'b0;
        i_Rst_L  = 1'b0;
        tick();
        ended = 1;
        return;
      end
      i_HReset  = ((cyc % period) == (period - 1));
      i_Trigger = 1'b1;
      if (retrig_at > 0 && !retrigged && lines == retrig_at && !i_HReset) begin
        i_Trigger = 1'b0;
        retrigged = 1;
      end
      out_b = o_Output;
      hr_b  = i_HReset;
      tick();
      cyc++;
      if (out_b && hr_b) lines++;
      if (o_Done) dones++;
      if (!o_Output) begin
        ended     = 1;
        i_HReset  = 1'b0;
        i_Trigger = 1'b1;
        tick();
        if (o_Done) dones++;
        return;
      end
    end
    i_HReset  = 1'b0;
    i_Trigger = 1'b1;
  endtask

  initial begin
    int  lines, dones, exp_pos;
    bit  ended, hi_seen;

    // Reset with trigger held low, then keep it low after release
    repeat (3) tick();
    check("rst_output", o_Output, 0);
    check("rst_done", o_Done, 0);
    check("rst_position", o_Position, 200);
    i_Rst_L = 1'b1;
    hi_seen = 0;
    repeat (100) begin
      tick();
      if (o_Output !== 1'b0) hi_seen = 1;
    end
    check("held_low_no_fire", hi_seen, 0);
    check("held_low_position", o_Position, 200);

    // Basic 200-line pulse; HReset coincident with start must not count
    i_Trigger = 1'b1;
    tick();
    fire(1'b1);
    check("rise_latency", o_Output, 1);
    run_pulse(16, 0, 0, lines, dones, ended);
    check("basic_ended", ended, 1);
    check("basic_lines", lines, 200);
    check("basic_dones", dones, 1);
    check("basic_position", o_Position, 200);

    // Second falling edge at line 50 of a 200-line pulse
    fire(1'b0);
    run_pulse(16, 50, 0, lines, dones, ended);
    check("retrig_ended", ended, 1);
`ifdef MONOSTABLE_RETRIGGER_EN
    check("retrig_lines", lines, 250);
`else
    check("retrig_lines", lines, 200);
`endif
    check("retrig_dones", dones, 1);
    check("retrig_position", o_Position, 200);

    // Down held across 60 triggers: saturates at 420
    i_Down = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      exp_pos = (200 + 4 * k > 420) ? 420 : 200 + 4 * k;
      fire(1'b0);
      check($sformatf("down_pos_%0d", k), o_Position, exp_pos);
      run_pulse(1, 0, 0, lines, dones, ended);
      if (k == 60) begin
        check("sat_ended", ended, 1);
        check("sat_lines", lines, 420);
        check("sat_dones", dones, 1);
      end
    end

    // Reset at line 100 of a pulse
    fire(1'b0);
    i_Down = 1'b0;
    run_pulse(16, 0, 100, lines, dones, ended);
    check("midrst_output", o_Output, 0);
    check("midrst_done", o_Done, 0);
    check("midrst_position", o_Position, 200);
    i_Rst_L = 1'b1;
    tick();
    fire(1'b0);
    check("post_rst_rise", o_Output, 1);
    run_pulse(16, 0, 0, lines, dones, ended);
    check("post_rst_lines", lines, 200);
    check("post_rst_dones", dones, 1);

    // Up held from 200 down to the floor of 2
    i_Up = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      exp_pos = (200 - 4 * k < 2) ? 2 : 200 - 4 * k;
      fire(1'b0);
      check($sformatf("up_pos_%0d", k), o_Position, exp_pos);
      run_pulse(1, 0, 0, lines, dones, ended);
    end
    i_Up = 1'b0; i_Down = 1'b1;
    fire(1'b0);
    check("down_to_6", o_Position, 6);
    run_pulse(1, 0, 0, lines, dones, ended);
    i_Up = 1'b1; i_Down = 1'b0;
    fire(1'b0);
    check("up_6_to_2", o_Position, 2);
    run_pulse(1, 0, 0, lines, dones, ended);
    fire(1'b0);
    check("up_stay_2", o_Position, 2);
    run_pulse(2, 0, 0, lines, dones, ended);
    check("min_lines", lines, 2);
    check("min_dones", dones, 1);
    i_Up = 1'b0; i_Down = 1'b1;
    fire(1'b0);
    check("down_again_6", o_Position, 6);
    run_pulse(1, 0, 0, lines, dones, ended);
    i_Up = 1'b1; i_Down = 1'b1;
    fire(1'b0);
    check("both_hold_6", o_Position, 6);
    run_pulse(1, 0, 0, lines, dones, ended);
    check("both_lines", lines, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
